// File: rtl/crc_pkg.sv
// Shared constants and helpers for the streaming CRC engine: standard polynomials,
// frame state encoding, byte reflection and keep-pattern helpers.
package crc_pkg;

    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam int          MAX_BYTES        = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } frame_state_t;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Lanes that are really processed: the unbroken run of ones starting at lane 0.
    function automatic logic [MAX_BYTES-1:0] keep_prefix(input logic [MAX_BYTES-1:0] keep);
        logic [MAX_BYTES-1:0] m;
        logic                 run;
        m   = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
            run  = run & keep[i];
            m[i] = run;
        end
        return m;
    endfunction

    function automatic logic keep_legal(input logic [MAX_BYTES-1:0] keep);
        return (keep != '0) && (keep == keep_prefix(keep));
    endfunction

    function automatic logic [3:0] popcount8(input logic [MAX_BYTES-1:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/crc_engine_if.sv
// Beat-in / result-out bundle of the CRC engine; the engine takes the slave side.
interface crc_engine_if #(
    parameter int CRC_W = 8,
    parameter int BYTES = 1
);
    logic                 s_valid;
    logic                 s_ready;
    logic [8*BYTES-1:0]   s_data;
    logic [BYTES-1:0]     s_keep;
    logic                 s_last;
    logic                 s_check;
    logic [CRC_W-1:0]     s_crc_ref;
    logic                 m_valid;
    logic                 m_ready;
    logic [CRC_W-1:0]     m_crc;
    logic                 m_match;
    logic [15:0]          m_bytes;
    logic                 m_err;

    modport master (
        output s_valid, s_data, s_keep, s_last, s_check, s_crc_ref, m_ready,
        input  s_ready, m_valid, m_crc, m_match, m_bytes, m_err
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, s_check, s_crc_ref, m_ready,
        output s_ready, m_valid, m_crc, m_match, m_bytes, m_err
    );
endinterface

// File: rtl/crc_byte_step.sv
// One byte of CRC update: eight MSB-first shift/XOR steps, optional input bit reversal.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = 'h07,
    parameter bit               REFIN = 1'b0
) (
    input  logic [CRC_W-1:0] i_crc_in,
    input  logic [7:0]       i_byte,
    output logic [CRC_W-1:0] o_crc_out
);

    logic [7:0]       w_data;
    logic [CRC_W-1:0] w_acc;

    assign w_data = REFIN ? reflect8(i_byte) : i_byte;

    always_comb begin
        w_acc = i_crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (w_acc[CRC_W-1] ^ w_data[i]) begin
                w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                w_acc = {w_acc[CRC_W-2:0], 1'b0};
            end
        end
    end

    assign o_crc_out = w_acc;

endmodule

// File: rtl/crc_engine.sv
// Streaming multi-lane CRC generator/checker with one result slot per frame.
// Lanes are chained combinationally; the running CRC and the result are registered.
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 'h07,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter int               BYTES   = 1
) (
    input  logic         clk,
    input  logic         reset,
    crc_engine_if.slave  bus
);

    frame_state_t r_state;
    frame_state_t w_state_next;

    logic [CRC_W-1:0]     r_crc;
    logic [15:0]          r_count;
    logic                 r_err;
    logic                 r_m_valid;
    logic [CRC_W-1:0]     r_m_crc;
    logic                 r_m_match;
    logic [15:0]          r_m_bytes;
    logic                 r_m_err;

    logic                 w_accept;
    logic                 w_end;
    logic [CRC_W-1:0]     w_crc_base;
    logic [15:0]          w_count_base;
    logic                 w_err_base;
    logic [MAX_BYTES-1:0] w_keep8;
    logic [MAX_BYTES-1:0] w_used;
    logic [CRC_W-1:0]     w_crc_next;
    logic [CRC_W-1:0]     w_crc_refl;
    logic [CRC_W-1:0]     w_crc_final;
    logic [16:0]          w_count_sum;
    logic [15:0]          w_count_next;
    logic                 w_err_next;

    assign bus.s_ready = !r_m_valid || bus.m_ready;
    assign w_keep8     = MAX_BYTES'(bus.s_keep);
    assign w_used      = keep_prefix(w_keep8);

    // Each lane either advances the CRC or passes it through, so an illegal keep
    // simply stops processing at the first disabled lane.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [CRC_W-1:0] w_in;
        logic [CRC_W-1:0] w_step;
        logic [CRC_W-1:0] w_out;

        if (gi == 0) begin : g_first
            assign w_in = w_crc_base;
        end else begin : g_chain
            assign w_in = g_lane[gi-1].w_out;
        end

        crc_byte_step #(
            .CRC_W (CRC_W),
            .POLY  (POLY),
            .REFIN (REFIN)
        ) u_step (
            .i_crc_in  (w_in),
            .i_byte    (bus.s_data[8*gi +: 8]),
            .o_crc_out (w_step)
        );

        assign w_out = w_used[gi] ? w_step : w_in;
    end

    assign w_crc_next = g_lane[BYTES-1].w_out;

    for (genvar gi = 0; gi < CRC_W; gi++) begin : g_refl
        assign w_crc_refl[gi] = w_crc_next[CRC_W-1-gi];
    end

    assign w_crc_final  = (REFOUT ? w_crc_refl : w_crc_next) ^ XOR_OUT;
    assign w_count_sum  = {1'b0, w_count_base} + 17'(popcount8(w_keep8));
    assign w_count_next = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
    assign w_err_next   = w_err_base | !keep_legal(w_keep8);

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = bus.s_last ? ST_IDLE : ST_BUSY;
        end
    end

    // An idle frame always starts from the init values, whatever the accumulators hold.
    always_comb begin
        w_accept     = bus.s_valid && bus.s_ready;
        w_end        = w_accept && bus.s_last;
        w_crc_base   = r_crc;
        w_count_base = r_count;
        w_err_base   = r_err;
        if (r_state == ST_IDLE) begin
            w_crc_base   = INIT;
            w_count_base = '0;
            w_err_base   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc     <= INIT;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_crc   <= '0;
            r_m_match <= 1'b0;
            r_m_bytes <= '0;
            r_m_err   <= 1'b0;
        end else if (w_end) begin
            r_crc     <= INIT;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_m_valid <= 1'b1;
            r_m_crc   <= w_crc_final;
            r_m_match <= bus.s_check && (w_crc_final == bus.s_crc_ref);
            r_m_bytes <= w_count_next;
            r_m_err   <= w_err_next;
        end else begin
            if (w_accept) begin
                r_crc   <= w_crc_next;
                r_count <= w_count_next;
                r_err   <= w_err_next;
            end
            if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_crc   = r_m_crc;
    assign bus.m_match = r_m_match;
    assign bus.m_bytes = r_m_bytes;
    assign bus.m_err   = r_m_err;

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised, streaming CRC engine for frame-oriented datapaths: the next generation of the team's fixed 8-bit CRC generator. Supports any CRC width/polynomial, configurable init, reflection and final XOR, and multiple byte lanes per beat with byte-keep. It accepts frames over a valid/ready input, emits one result per frame over a valid/ready output, and optionally compares the result against a reference CRC, so one block serves both generator and checker roles.

## Interface
- CRC_W, 8: CRC width in bits (8..32).
- POLY, 8'h07: generator polynomial, implicit top bit omitted, CRC_W bits.
- INIT, 0: CRC register value at the start of every frame.
- XOR_OUT, 0: value XORed into the final CRC.
- REFIN, 0: 1 = process each input byte LSB first.
- REFOUT, 0: 1 = bit-reverse the whole CRC_W register before XOR_OUT.
- BYTES, 1: byte lanes per beat (1..8); lane 0 is s_data[7:0] and is processed first.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine can accept a beat.
- s_data  in  8*BYTES  input bytes.
- s_keep  in  BYTES  lane enables; contiguous from lane 0; not all-zero.
- s_last  in  1  final beat of frame.
- s_check  in  1  sampled with s_last; 1 = checker mode for this frame.
- s_crc_ref  in  CRC_W  reference CRC, sampled with s_last.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_crc  out  CRC_W  final CRC (after REFOUT and XOR_OUT).
- m_match  out  1  checker mode: m_crc == s_crc_ref; generator mode: 0.
- m_bytes  out  16  frame byte count, saturating at 16'hFFFF.
- m_err  out  1  frame contained an illegal keep pattern.

## Operation
- Beat accepted when s_valid && s_ready. s_ready = !m_valid || m_ready (result slot free or draining this cycle).
- Running register crc_q. Per accepted beat: kept lanes are processed in order 0..BYTES-1, each as 8 MSB-first shift/XOR steps (data bit XOR crc MSB; if 1, shift and XOR POLY, else shift). With REFIN=1 each byte is bit-reversed first.
- Frame state FSM: IDLE (no bytes accepted since the last result) → BUSY on a non-last beat; BUSY → IDLE on the last beat; IDLE → IDLE on a single-beat frame.
- Last beat: the final value = reflect(crc_next, REFOUT) ^ XOR_OUT is loaded into m_crc; m_match, m_bytes and m_err are loaded; m_valid is set; crc_q, count and err are reloaded to INIT, 0 and 0.
- Byte count adds popcount(s_keep) per beat and saturates.
- Illegal keep (zero, or non-contiguous): the beat is still accepted, only lanes from lane 0 up to the first 0 are used, and the frame's m_err is set. Partial keep on a non-last beat is legal (no error).
- Output held stable while m_valid && !m_ready. It clears on m_ready unless a new last beat loads it in the same cycle.
- Reset (any state, including mid-frame): crc_q=INIT, FSM=IDLE, m_valid=0, m_crc=0, m_match=0, m_bytes=0, m_err=0, count=0. Any partial frame is discarded.

## Timing
- Per-beat update is combinational through BYTES lanes, with one register stage.
- Latency: m_valid is asserted the cycle after the last beat is accepted.
- Throughput: one beat per cycle and back-to-back frames with no gap when m_ready=1. With m_valid=1 and m_ready=0, s_ready=0.
- Simultaneous last-beat accept and result drain: the new result replaces the old one in the same edge, and m_valid stays 1.

## Structure
- Package crc_pkg: standard polynomial constants (CRC8 8'h07, CRC16_CCITT 16'h1021, CRC32 32'h04C11DB7), the reflect8 function, and the keep-validity/popcount helper functions.
- Sub-module crc_byte_step: combinational, parameters CRC_W, POLY, REFIN; inputs crc_in and byte; output crc_out. The top instantiates BYTES copies chained, with a bypass mux per lane driven by keep.
- The top contains the FSM, counters, output register and handshake.

## Test plan
- CRC_W=8, POLY=07, INIT=0, BYTES=1; "123456789" one byte per beat → m_crc=8'hF4, m_bytes=9, m_valid one cycle after last.
- CRC-32 (POLY 04C11DB7, INIT/XOR_OUT FFFFFFFF, REFIN=REFOUT=1, BYTES=4); "123456789" as 4+4+1 keep=4'b0001 → m_crc=32'hCBF43926, m_err=0.
- CRC-16 (1021, INIT FFFF, no reflect, BYTES=2); same string, s_check=1, s_crc_ref=16'h29B1 → m_match=1; repeat with ref 16'h29B0 → m_match=0.
- Backpressure: hold m_ready=0 after a result, then drive the next frame → s_ready=0 and m_crc stable. Raise m_ready on the next frame's last beat → new result loads the same cycle and m_valid stays 1.
- Reset mid-frame after 5 bytes, then "123456789" (CRC-8 config) → m_crc=8'hF4, m_bytes=9, no residue from the aborted frame.
- keep=2'b10 on a BYTES=2 frame → m_err=1, lane 1 ignored, m_bytes counts 1.
